// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared types and helpers for the multi-cycle chunked adder.
//   state_t   : control FSM states (IDLE, RUN, DONE)
//   cnt_width : width of a counter that indexes nchunk chunks (minimum 1 bit)
// -----------------------------------------------------------------------------
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter so that the
    // counter logic elaborates uniformly.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_n_bits.sv
// -----------------------------------------------------------------------------
// adder_n_bits
// Combinational WIDTH-bit ripple adder slice, reused once per cycle by the
// sequential adder.
//   A_i, B_i : operands
//   Cin_i    : carry in
//   S_o      : sum, modulo 2^WIDTH
//   Cout_o   : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_n_bits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Cin_i,
    output logic [WIDTH-1:0] S_o,
    output logic             Cout_o
);

    assign {Cout_o, S_o} = {1'b0, A_i} + {1'b0, B_i} + {{WIDTH{1'b0}}, Cin_i};

endmodule

// File: rtl/adder_seq_n_bits.sv
// -----------------------------------------------------------------------------
// adder_seq_n_bits
// Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice is reused for
// WIDTH/CHUNK cycles, LSB chunk first, with the carry held in a register.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   start_i  : request, accepted when start_i && ready_o on a rising edge
//   sub_i    : 0 = A+B+Cin, 1 = A-B (Cin_i ignored)
//   A_i, B_i : operands, sampled at accept
//   Cin_i    : carry in for add, sampled at accept
//   ready_o  : can accept (IDLE or DONE)
//   busy_o   : operation in progress (RUN)
//   done_o   : one-cycle pulse, result valid from this cycle on
//   S_o      : registered result, held until the next done_o
//   Cout_o   : registered carry out (for sub, 1 = no borrow)
//   V_o, Z_o : signed overflow / zero flags, only with ADDER_SEQ_FLAGS_EN
//
// Build option: define ADDER_SEQ_FLAGS_EN to add the V_o / Z_o flag ports.
// -----------------------------------------------------------------------------
module adder_seq_n_bits
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Cin_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] S_o,
    output logic             Cout_o
`ifdef ADDER_SEQ_FLAGS_EN
    ,
    output logic             V_o,
    output logic             Z_o
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $fatal(1, "adder_seq_n_bits: WIDTH must be a multiple of CHUNK");
    end

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             last_chunk;

    // Operand and accumulator registers carry no reset: every chunk of the
    // accumulator is overwritten before it is ever read.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;

    logic [IDX_W-1:0] base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    // ---------------------------------------------------------------------
    // Chunk selection and the shared slice
    // ---------------------------------------------------------------------
    assign base       = IDX_W'(int'(cnt) * CHUNK);
    assign a_chunk    = a_reg[base +: CHUNK];
    assign b_chunk    = b_reg[base +: CHUNK];
    assign last_chunk = (cnt == LAST);

    adder_n_bits #(
        .WIDTH (CHUNK)
    ) u_slice (
        .A_i    (a_chunk),
        .B_i    (b_chunk),
        .Cin_i  (carry),
        .S_o    (slice_sum),
        .Cout_o (slice_cout)
    );

    // Accumulator with the current partial sum merged in, so the final
    // chunk can be written straight to S_o on the last RUN edge.
    always_comb begin
        acc_next               = acc;
        acc_next[base +: CHUNK] = slice_sum;
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        next_state = state;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_chunk) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                ready_o = 1'b1;
                if (start_i) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= last_chunk ? '0 : cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath: operand latch, per-chunk accumulate, running carry
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (load) begin
            a_reg <= A_i;
            b_reg <= sub_i ? ~B_i : B_i;
            carry <= sub_i ? 1'b1 : Cin_i;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= slice_cout;
        end
    end

    // ---------------------------------------------------------------------
    // Result registers: updated only on the edge that enters DONE
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            S_o    <= '0;
            Cout_o <= 1'b0;
        end else if (state == RUN && last_chunk) begin
            S_o    <= acc_next;
            Cout_o <= slice_cout;
        end
    end

`ifdef ADDER_SEQ_FLAGS_EN
    // Carry into the MSB recovered from the top bit of the final chunk:
    // sum = a ^ b ^ cin, so cin = a ^ b ^ sum.
    logic msb_cin;
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            V_o <= 1'b0;
            Z_o <= 1'b0;
        end else if (state == RUN && last_chunk) begin
            V_o <= msb_cin ^ slice_cout;
            Z_o <= (acc_next == '0);
        end
    end
`else
    // Flag outputs not built: only S_o and Cout_o are produced.
`endif

endmodule

// File: doc/adder_seq_n_bits.md
# adder_seq_n_bits

Multi-cycle, parametrised successor to the combinational n-bit adder. Performs WIDTH-bit addition or subtraction over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, reusing one CHUNK-bit adder slice. Targets area-constrained datapaths next to the ALU and has a start/ready/done handshake so a controller can issue back-to-back operations.

## Interface
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- start_i  in  1  request; accepted on an edge where start_i && ready_o.
- sub_i  in  1  0 = A+B+Cin, 1 = A-B (B inverted, carry-in forced to 1, Cin_i ignored).
- A_i  in  WIDTH  operand A, sampled at accept.
- B_i  in  WIDTH  operand B, sampled at accept.
- Cin_i  in  1  carry-in for add, sampled at accept.
- ready_o  out  1  high in IDLE and DONE.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse; S_o and Cout_o are valid from this cycle on.
- S_o  out  WIDTH  registered result; held until the next done_o.
- Cout_o  out  1  registered carry-out; for sub, 1 means no borrow.
- V_o, Z_o  out  1  signed overflow and zero flags. Present only with the feature macro, see Configuration.

## Operation
- NCHUNK = WIDTH/CHUNK. State machine states: IDLE, RUN, DONE.
- IDLE: ready_o=1. On accept, latch A, B (or ~B if sub), and carry (Cin_i, or 1 if sub); clear the chunk counter; go to RUN.
- RUN: each cycle, add chunk[cnt] of A and B plus the running carry through the slice. Store the partial sum into chunk cnt of the accumulator, update the carry, then increment cnt. After chunk NCHUNK-1: load S_o and Cout_o from the accumulator and final carry, go to DONE. start_i is ignored in RUN.
- DONE: done_o=1, ready_o=1. On accept, latch new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- Arithmetic is modulo 2^WIDTH. The carry chain runs LSB chunk first. The operand registers are not visible on outputs.
- CHUNK == WIDTH is legal: the block degenerates to a single RUN cycle.
- Reset, including mid-operation: state goes to IDLE and cnt to 0. All outputs go to 0 except ready_o, which goes to 1. S_o, Cout_o, V_o and Z_o are 0. No done_o is generated for the aborted operation.

## Timing
- Accept on edge k → RUN on cycles k+1..k+NCHUNK → done_o high in the cycle after edge k+NCHUNK.
- Latency is NCHUNK cycles from the accept edge to done_o.
- Maximum throughput is one result per NCHUNK+1 cycles, with start_i held high through DONE.
- Outputs change only on the edge entering DONE, so there is no combinational path from inputs to outputs.
- done_o never lasts more than one cycle. Back-to-back results give non-adjacent pulses.

## Configuration
- ADDER_SEQ_FLAGS_EN defined:
  - V_o and Z_o exist and are registered together with S_o.
  - V_o = carry into MSB XOR carry out of MSB.
  - Z_o = (result == 0).
- ADDER_SEQ_FLAGS_EN undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Package adder_seq_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE};
  - helper function clog2-based counter width for NCHUNK.
- Sub-module: one instance of adder_n_bits #(CHUNK) as the per-cycle slice. Its Cin_i is the running carry; its Cout_o is the next carry.
- The carry into the MSB (needed for V_o) is taken from a bit-level recompute of the top bit in the final chunk.

## Test plan
Default WIDTH=32, CHUNK=8, so NCHUNK=4.
- Add 0x12345678 + 0xFEDCBA98, Cin=0 → S_o=0x11111110, Cout_o=1; done_o exactly 4 cycles after the accept edge.
- Same operands with Cin=1 → S_o=0x11111111, Cout_o=1. Also 0+0, Cin=0 → S_o=0, Cout_o=0, Z_o=1.
- Sub 0x00000001 - 0x00000002 → S_o=0xFFFFFFFF, Cout_o=0, V_o=0, Z_o=0. Sub 5-5 → S_o=0, Cout_o=1, Z_o=1.
- Flags:
  - 0x7FFFFFFF + 1 → S_o=0x80000000, V_o=1, Cout_o=0.
  - 0xFFFFFFFF + 1 → S_o=0, Cout_o=1, Z_o=1, V_o=0.
- start_i held high with alternating operands:
  - done_o pulses every 5 cycles and results match in order.
  - start_i pulses during RUN are ignored, and S_o is unaffected until the next done_o.
- Assert rst_n_i in the 2nd RUN cycle:
  - all outputs go to reset values immediately, with no done_o.
  - after release, a new add of 3+4 gives S_o=7 four cycles after accept.
  - repeat with CHUNK=32 → latency 1.
